// File: rtl/sample_pkg.sv
// ---------------------------------------------------------------------------
// sample_pkg
// Shared definitions for the sample storage readout path: default address
// and sample widths, plus the readout controller state encoding.
// ---------------------------------------------------------------------------
package sample_pkg;

  localparam int SAMPLE_AW = 10;  // 1024-entry sample memory
  localparam int SAMPLE_DW = 8;   // signed sample width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO holding returned samples until downstream accepts them.
// Storage is registered; the head entry is read combinationally.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push         write push_data this cycle
//   push_data    signed sample to store
//   pop          remove the head entry this cycle
//   head         signed value at the head of the FIFO
//   full, empty  occupancy flags
//   count        number of stored entries (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module sample_fifo
  import sample_pkg::*;
#(
  parameter int DW         = SAMPLE_DW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic signed [DW-1:0]              push_data,
  input  logic                              pop,
  output logic signed [DW-1:0]              head,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH):0]       count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic signed [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_push, do_pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sample_readout.sv
// ---------------------------------------------------------------------------
// sample_readout
// Reads a window of the sample storage memory and streams the returned
// signed samples downstream. Reads are issued only when the output FIFO is
// guaranteed to have room for every outstanding return, so backpressure
// never causes a sample to be lost.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle launch pulse (ignored unless idle)
//   start_addr        first address of the window (sampled on start)
//   num_samples       window length 0..2^AW (sampled on start)
//   sample_addr       read address to storage (holds when no read)
//   sample_read       one-cycle read strobe to storage
//   sample_read_out   signed storage data, valid RD_LAT cycles after strobe
//   sample_out        signed streamed sample
//   sample_valid      sample_out is valid
//   sample_ready      downstream accepts sample_out
//   busy              readout in progress
//   done              one-cycle completion pulse
// ---------------------------------------------------------------------------
module sample_readout
  import sample_pkg::*;
#(
  parameter int AW         = SAMPLE_AW,
  parameter int DW         = SAMPLE_DW,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW:0]          num_samples,
  output logic [AW-1:0]        sample_addr,
  output logic                 sample_read,
  input  logic signed [DW-1:0] sample_read_out,
  output logic signed [DW-1:0] sample_out,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        last_addr_q, last_addr_d;
  logic [AW:0]          rem_q, rem_d;
  logic [RD_LAT-1:0]    pipe_q, pipe_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        occupancy;
  logic                 issue;
  logic                 credit_ok;
  logic                 pipe_exit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic signed [DW-1:0] fifo_head;

  // Credit is computed from registered counts only: a pop this cycle frees
  // its slot for issue decisions starting next cycle.
  assign pipe_exit = pipe_q[RD_LAT-1];
  assign occupancy = fifo_count + inflight_q;
  assign credit_ok = !fifo_full && (occupancy < CW'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = num_samples;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if ((rem_q != '0) && credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - (AW+1)'(1);
        end
        if ((rem_q == '0) || (issue && (rem_q == (AW+1)'(1)))) state_d = DRAIN;
      end
      DRAIN: begin
        if ((inflight_q == '0) && fifo_empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe flags march through the pipe; the flag leaving it marks the cycle
  // in which storage presents the matching sample.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    inflight_d = inflight_q;
    if (issue && !pipe_exit)      inflight_d = inflight_q + CW'(1);
    else if (!issue && pipe_exit) inflight_d = inflight_q - CW'(1);

    last_addr_d = issue ? addr_q : last_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      pipe_q      <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rem_q       <= rem_d;
      pipe_q      <= pipe_d;
      inflight_q  <= inflight_d;
    end
  end

  assign sample_read  = issue;
  assign sample_addr  = issue ? addr_q : last_addr_q;
  assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign sample_valid = !fifo_empty;
  assign fifo_pop     = sample_valid && sample_ready;
  // FIFO storage is not reset, so mask the head while nothing is valid.
  assign sample_out   = fifo_empty ? '0 : fifo_head;

  sample_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_exit),
    .push_data (sample_read_out),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sample_readout.sv
// ---------------------------------------------------------------------------
// tb_sample_readout
// Self-checking bench for sample_readout with a RD_LAT=1 storage model whose
// entry i holds i[7:0]. Expected read addresses and output samples for each
// readout are generated from the window arithmetic and consumed as the DUT
// strobes reads and hands samples downstream.
// ---------------------------------------------------------------------------
module tb_sample_readout;

  localparam int AW         = 10;
  localparam int DW         = 8;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_N      = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        start_addr;
  logic [AW:0]          num_samples;
  logic [AW-1:0]        sample_addr;
  logic                 sample_read;
  logic signed [DW-1:0] sample_read_out = '0;
  logic signed [DW-1:0] sample_out;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  sample_readout #(
    .AW         (AW),
    .DW         (DW),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .start_addr      (start_addr),
    .num_samples     (num_samples),
    .sample_addr     (sample_addr),
    .sample_read     (sample_read),
    .sample_read_out (sample_read_out),
    .sample_out      (sample_out),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .busy            (busy),
    .done            (done)
  );

  // Storage model: one-cycle registered read, mem[i] = i[7:0].
  logic [7:0] mem [MEM_N];
  initial for (int i = 0; i < MEM_N; i++) mem[i] = 8'(i);
  always @(posedge clk) if (sample_read) sample_read_out <= mem[sample_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference expectations for the current readout.
  logic [AW-1:0] exp_addr [$];
  logic [7:0]    exp_data [$];
  int iss_cnt, pop_cnt, done_cnt;

  always @(negedge clk) begin : monitor
    logic [AW-1:0] a;
    logic [7:0]    d;
    if (rst_n === 1'b1) begin
      if (sample_read) begin
        // Reads outstanding (issued but not yet handed downstream) never exceed the buffer.
        check("outstanding_le_depth", 32'((iss_cnt - pop_cnt) < FIFO_DEPTH), 32'd1);
        if (exp_addr.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else begin
          a = exp_addr.pop_front();
          check("read_addr", 32'(sample_addr), 32'(a));
        end
        iss_cnt++;
      end
      if (sample_valid && sample_ready) begin
        if (exp_data.size() == 0) check("unexpected_sample", 32'd1, 32'd0);
        else begin
          d = exp_data.pop_front();
          check("sample_data", 32'($unsigned(sample_out)), 32'(d));
        end
        pop_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // mode 0: ready always high; mode 1: ready low for cycles 1..10; mode 2: random ready.
  // extra_at: cycle at which a second (ignored) start is pulsed; rst_at: cycle of reset abort.
  task automatic run(input int sa, input int n, input int mode, input int extra_at, input int rst_at);
    int cyc;
    int done_cyc;
    int bound;
    iss_cnt  = 0;
    pop_cnt  = 0;
    done_cnt = 0;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'((sa + i) % MEM_N));
      exp_data.push_back(8'((sa + i) % 256));
    end
    start        = 1'b1;
    start_addr   = AW'(sa);
    num_samples  = (AW+1)'(n);
    sample_ready = (mode == 0);
    @(posedge clk); #1;
    start       = 1'b0;
    start_addr  = AW'($urandom_range(0, MEM_N - 1));
    num_samples = (AW+1)'($urandom_range(0, MEM_N));
    cyc      = 1;
    done_cyc = -1;
    bound    = n * 20 + 60;
    while (cyc <= bound) begin
      case (mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = (cyc > 10);
        default: sample_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = (cyc == extra_at);
      if (cyc == extra_at) begin
        start_addr  = AW'($urandom_range(0, MEM_N - 1));
        num_samples = (AW+1)'(5);
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_sample_read", 32'(sample_read), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sample_out", 32'($unsigned(sample_out)), 32'd0);
        check("rst_sample_addr", 32'(sample_addr), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        return;
      end
      if (cyc == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("first_read_latency", 32'(sample_read), 32'(n != 0));
      end
      if (cyc == 2) check("valid_before_latency", 32'(sample_valid), 32'd0);
      if (cyc == 3) check("first_valid_latency", 32'(sample_valid), 32'(n != 0));
      if (mode == 1 && cyc >= 3 && cyc <= 10) check("valid_held_stalled", 32'(sample_valid), 32'd1);
      if (mode == 1 && cyc == 10) check("reads_while_stalled", 32'(iss_cnt), 32'(FIFO_DEPTH));
      if (done) begin
        done_cyc = cyc;
        check("busy_low_in_done", 32'(busy), 32'd0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    if (mode == 0) check("done_cycle", 32'(done_cyc), (n == 0) ? 32'd3 : 32'(n + 4));
    sample_ready = 1'b1;
    start        = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("samples_out", 32'(pop_cnt), 32'(n));
    check("reads_issued", 32'(iss_cnt), 32'(n));
    check("expected_left", 32'(exp_data.size()), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    start_addr   = '0;
    num_samples  = '0;
    sample_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sample_read", 32'(sample_read), 32'd0);
    check("reset_sample_valid", 32'(sample_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sample_addr", 32'(sample_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(5, 4, 0, 0, 0);        // basic readout
    run(10, 8, 1, 0, 0);       // backpressure
    run(1022, 4, 0, 0, 0);     // address wrap, values -2,-1,0,1
    run(300, 0, 0, 0, 0);      // zero length
    run(40, 16, 0, 5, 0);      // second start while busy is ignored
    run(60, 16, 0, 0, 6);      // reset aborts mid-readout
    run(77, 6, 0, 0, 0);       // fresh readout after reset
    for (int k = 0; k < 12; k++)
      run($urandom_range(0, MEM_N - 1), $urandom_range(0, 40), 2, 0, 0);
    run($urandom_range(0, MEM_N - 1), MEM_N, 2, 0, 0);  // full-memory window

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
